// File: rtl/w_tap_bank_pkg.sv
// rtl/w_tap_bank_pkg.sv - shared types and constants for the weight/tap register bank
//
// Purpose: FSM state encoding, the Q-format unity constant and the tap-index
//          width helper used by the bank, its interface and the testbench.
// Build option: W_BANK_CENTER_INIT_EN selects whether reset loads the centre
//               weight with 1.0 (identity-like start) or clears every weight.
// Ports: none (package).

package w_tap_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int QP_DEFAULT = 12;
    localparam int ONE_Q      = 1 << QP_DEFAULT;

    // Value 1.0 for an arbitrary number of fractional bits.
    function automatic int one_q(input int qp);
        return 1 << qp;
    endfunction

    // Width of a tap index; never narrower than one bit.
    function automatic int tap_aw(input int taps);
        return (taps > 2) ? $clog2(taps) : 1;
    endfunction

`ifdef W_BANK_CENTER_INIT_EN
    localparam bit CENTER_INIT = 1'b1;
`else
    localparam bit CENTER_INIT = 1'b0;
`endif

endpackage

// File: rtl/w_tap_bank_if.sv
// rtl/w_tap_bank_if.sv - signal bundle between the tap bank, its sample source, update term and reader
//
// Purpose: groups the sample handshake, the update-term operand/result path,
//          the weight read port and the pass status flags.
// Modports:
//   slave  - the bank: takes start/x_in/mu_error/upd_new_weight/rd_addr,
//            drives upd_mu_error/upd_x_n/upd_weight/rd_data/busy/done
//   master - the surrounding datapath (mirror image of slave)

interface w_tap_bank_if
    import w_tap_bank_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8
);
    localparam int AW = tap_aw(TAPS);

    logic             start;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] mu_error;
    logic [WIDTH-1:0] upd_mu_error;
    logic [WIDTH-1:0] upd_x_n;
    logic [WIDTH-1:0] upd_weight;
    logic [WIDTH-1:0] upd_new_weight;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;

    modport slave (
        input  start, x_in, mu_error, upd_new_weight, rd_addr,
        output upd_mu_error, upd_x_n, upd_weight, rd_data, busy, done
    );

    modport master (
        output start, x_in, mu_error, upd_new_weight, rd_addr,
        input  upd_mu_error, upd_x_n, upd_weight, rd_data, busy, done
    );

endinterface

// File: rtl/w_tap_delay_line.sv
// rtl/w_tap_delay_line.sv - TAPS-deep input sample delay line with parallel outputs
//
// Purpose: on load, taps[0] takes din and every older sample moves one slot
//          deeper; the oldest sample falls off the end.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low clear
//   load  in  shift enable
//   din   in  new sample
//   taps  out all stored samples, taps[0] newest

module w_tap_delay_line #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [WIDTH-1:0]            din,
    output logic [TAPS-1:0][WIDTH-1:0]  taps
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (load) begin
            taps <= {taps[TAPS-2:0], din};
        end
    end

endmodule

// File: rtl/w_tap_bank.sv
// rtl/w_tap_bank.sv - FIR weight bank and tap delay line sequenced around the weight-update term
//
// Purpose: each accepted start shifts in a new sample, latches mu_error and
//          walks c = 0..TAPS, presenting x[c] and (one cycle later) weight[c-1]
//          to the update term and writing its result back into weight[c-1].
//          A DONE cycle then pulses done. Starts while busy are dropped.
// Build option: W_BANK_CENTER_INIT_EN (reset weight[TAPS/2] = 1.0).
// Ports:
//   clk   in     system clock, rising edge
//   reset in     asynchronous active-low reset, clears everything
//   bus   slave  start/x_in/mu_error in, upd_* operands out, upd_new_weight in,
//                rd_addr in / rd_data out (combinational), busy/done out

module w_tap_bank
    import w_tap_bank_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QP    = 12,
    parameter int TAPS  = 8,
    parameter int AW    = tap_aw(TAPS)
) (
    input  logic          clk,
    input  logic          reset,
    w_tap_bank_if.slave   bus
);

    localparam int CW = $clog2(TAPS + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t             LAST  = cnt_t'(TAPS);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(one_q(QP));

    state_t                      state, state_n;
    cnt_t                        cnt, cnt_n, cnt_m1;
    logic                        shift_en;
    logic                        wr_en;
    logic [WIDTH-1:0]            mu_hold;
    logic [WIDTH-1:0]            weight [TAPS];
    logic [TAPS-1:0][WIDTH-1:0]  x_tap;
    logic [AW-1:0]               x_idx;
    logic [AW-1:0]               w_idx;

    w_tap_delay_line #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_delay (
        .clk   (clk),
        .rst_n (reset),
        .load  (shift_en),
        .din   (bus.x_in),
        .taps  (x_tap)
    );

    // Weight index trails the sample index by one cycle to line up with the
    // registered product inside the update term.
    assign cnt_m1 = cnt - cnt_t'(1);
    assign x_idx  = cnt[AW-1:0];
    assign w_idx  = cnt_m1[AW-1:0];
    assign wr_en  = (state == ST_UPDATE) && (cnt != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shift_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_en = 1'b1;
                    cnt_n    = '0;
                    state_n  = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (cnt == LAST) begin
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt + cnt_t'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mu_hold <= '0;
        end else if (shift_en) begin
            mu_hold <= bus.mu_error;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                weight[i] <= (CENTER_INIT && (i == TAPS / 2)) ? ONE_W : '0;
            end
        end else if (wr_en) begin
            weight[w_idx] <= bus.upd_new_weight;
        end
    end

    // Operands are forced to zero outside their valid slots so the term sees
    // a clean zero product at c=TAPS and a zero weight at c=0.
    always_comb begin
        bus.upd_x_n    = '0;
        bus.upd_weight = '0;
        if (state == ST_UPDATE) begin
            if (cnt != LAST) begin
                bus.upd_x_n = x_tap[x_idx];
            end
            if (cnt != '0) begin
                bus.upd_weight = weight[w_idx];
            end
        end
    end

    assign bus.upd_mu_error = mu_hold;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.done         = (state == ST_DONE);

    generate
        if ((1 << AW) == TAPS) begin : g_rd_full
            assign bus.rd_data = weight[bus.rd_addr];
        end else begin : g_rd_guard
            assign bus.rd_data = (bus.rd_addr < AW'(TAPS)) ? weight[bus.rd_addr] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_w_tap_bank.sv
// tb/tb_w_tap_bank.sv - scoreboard testbench for w_tap_bank with a behavioural update term

module tb_w_tap_bank;
    import w_tap_bank_pkg::*;

    localparam int WIDTH = 16;
    localparam int QP    = 12;
    localparam int TAPS  = 8;
    localparam int AW    = $clog2(TAPS);

    typedef struct packed {
        logic [TAPS-1:0][WIDTH-1:0] w;
        logic [WIDTH-1:0]           mu;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #20 clk = ~clk;

    w_tap_bank_if #(.WIDTH(WIDTH), .TAPS(TAPS)) bus();

    w_tap_bank #(.WIDTH(WIDTH), .QP(QP), .TAPS(TAPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    exp_t             sb[$];
    logic [WIDTH-1:0] ref_w [TAPS];
    logic [WIDTH-1:0] ref_x [TAPS];

    function automatic logic [WIDTH-1:0] scaled(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return WIDTH'(p >>> QP);
    endfunction

    // Update term: product registered one cycle, sum returned combinationally.
    logic [WIDTH-1:0] prod_q;
    always @(posedge clk) prod_q <= scaled(bus.upd_x_n, bus.upd_mu_error);
    assign bus.upd_new_weight = bus.upd_weight + prod_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic ref_reset();
        for (int i = 0; i < TAPS; i++) begin
            ref_x[i] = '0;
            ref_w[i] = '0;
        end
`ifdef W_BANK_CENTER_INIT_EN
        ref_w[TAPS/2] = 16'h1000;
`endif
    endtask

    // One pass: newest sample enters slot 0, then every weight moves by x*mu.
    task automatic model_accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] mu);
        exp_t e;
        for (int i = TAPS - 1; i > 0; i--) ref_x[i] = ref_x[i-1];
        ref_x[0] = x;
        for (int i = 0; i < TAPS; i++) begin
            ref_w[i] = ref_w[i] + scaled(ref_x[i], mu);
            e.w[i]   = ref_w[i];
        end
        e.mu = mu;
        sb.push_back(e);
    endtask

    task automatic issue_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] mu, input bit accept);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.x_in     = x;
        bus.mu_error = mu;
        if (accept) model_accept(x, mu);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at the negedge after the start edge; returns just after the
    // edge that leaves DONE so the next start lands in IDLE.
    task automatic wait_done(input bit chk_lat);
        int  lat;
        bit  seen;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("done_timeout");
        else if (chk_lat) check("done_latency", lat, TAPS + 2);
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input int idx, input logic [WIDTH-1:0] exp, input string name);
        bus.rd_addr = AW'(idx);
        #1;
        check(name, bus.rd_data, exp);
    endtask

    // Monitor: mu hold stability during a pass, full weight vector at done.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (bus.busy) begin
                    if (sb.size() == 0) fail_now("busy_without_start");
                    else check("mu_hold", bus.upd_mu_error, sb[0].mu);
                end
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        fail_now("done_without_start");
                    end else begin
                        e = sb.pop_front();
                        for (int i = 0; i < TAPS; i++) begin
                            bus.rd_addr = AW'(i);
                            #1;
                            check("done_weight", bus.rd_data, e.w[i]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] old_w2;
        bus.start    = 1'b0;
        bus.x_in     = '0;
        bus.mu_error = '0;
        bus.rd_addr  = '0;
        ref_reset();

        #5 reset = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_upd_x", bus.upd_x_n, 0);
        check("rst_upd_w", bus.upd_weight, 0);
        check("rst_upd_mu", bus.upd_mu_error, 0);
        for (int i = 0; i < TAPS; i++) read_check(i, ref_w[i], "rst_weight");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed passes from the reference sequence.
        issue_start(16'h1000, 16'h0800, 1'b1);
        wait_done(1'b1);
        @(negedge clk);
        read_check(0, 16'h0800, "pass1_w0");
        issue_start(16'h2000, 16'h0400, 1'b1);
        wait_done(1'b1);
        @(negedge clk);
        read_check(0, 16'h1000, "pass2_w0");
        read_check(1, 16'h0400, "pass2_w1");

        // Starts at c=3 and in DONE must be dropped.
        issue_start(WIDTH'($urandom), 16'h0300, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.x_in = 16'h7abc; bus.mu_error = 16'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("done_at_c_end", bus.done, 1);
        @(negedge clk);
        bus.start = 1'b1; bus.x_in = 16'h5555; bus.mu_error = 16'h0f0f;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("start_in_done_ignored", bus.busy, 0);
        issue_start(WIDTH'($urandom), 16'h0200, 1'b1);
        wait_done(1'b1);

        // Read port during a pass: weight[2] changes on the edge ending c=3.
        old_w2 = ref_w[2];
        issue_start(WIDTH'($urandom), 16'h0800, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bus.rd_addr = AW'(2);
        #1;
        check("rd_w2_before", bus.rd_data, old_w2);
        check("c3_upd_x", bus.upd_x_n, ref_x[3]);
        check("c3_upd_w", bus.upd_weight, old_w2);
        @(posedge clk);
        #1;
        check("rd_w2_after", bus.rd_data, ref_w[2]);
        wait_done(1'b0);

        // Reset aborts a pass at c=5.
        issue_start(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
        repeat (5) @(posedge clk);
        #5 reset = 1'b0;
        sb.delete();
        ref_reset();
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_upd_x", bus.upd_x_n, 0);
        check("abort_upd_w", bus.upd_weight, 0);
        check("abort_upd_mu", bus.upd_mu_error, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < TAPS; i++) read_check(i, ref_w[i], "abort_weight");
        issue_start(16'h1000, 16'h0800, 1'b1);
        wait_done(1'b1);

        // Randomised passes with random idle gaps.
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue_start(WIDTH'($urandom), WIDTH'($urandom), 1'b1);
            wait_done(1'b1);
        end

        repeat (2) @(posedge clk);
        if (sb.size() != 0) fail_now("scoreboard_not_empty");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w_tap_bank.md
Name: w_tap_bank

Overview:
- Register bank holding the FIR weight vector and the input tap delay line for the adaptive linear stage.
- Sits directly around the weight-update term, time-multiplexed over all taps. Feeds it the mu_error, x_n and weight operands and writes its new_weight result back into the bank.
- One update pass per accepted sample.
- Exposes a read port so the filter-output stage can fetch weights.

Parameters:
- WIDTH, 16, datapath word width (two's complement, Q(WIDTH-QP).QP)
- QP, 12, fractional bits; the value 1.0 is 1<<QP
- TAPS, 8, number of weights and x taps (minimum 2)
- AW, $clog2(TAPS), width of the tap index

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state
- start  in  1  single-cycle pulse: new sample plus new mu_error available
- x_in  in  WIDTH  new input sample x(n)
- mu_error  in  WIDTH  mu*e(n) for this update
- upd_mu_error  out  WIDTH  held mu_error to the update term
- upd_x_n  out  WIDTH  tap sample to the update term
- upd_weight  out  WIDTH  current weight to the update term
- upd_new_weight  in  WIDTH  updated weight returned by the term (one-cycle product latency)
- rd_addr  in  AW  weight read index
- rd_data  out  WIDTH  weight[rd_addr], combinational from registers
- busy  out  1  high while an update pass is in progress
- done  out  1  single-cycle pulse when the pass completes

Behaviour:
- Reset (reset=0, asynchronous):
  - All weights and x taps cleared to 0; mu_error hold register cleared to 0.
  - State goes to IDLE; busy=0, done=0; upd_* outputs = 0.
- States: IDLE, UPDATE, DONE.
- IDLE:
  - On start=1: shift the delay line (x[0]<=x_in, x[i]<=x[i-1], x[TAPS-1] discarded).
  - On the same edge: latch mu_error into the hold register, clear the counter c to 0, go to UPDATE.
  - start=0 leaves all state unchanged.
- UPDATE lasts TAPS+1 cycles, counter c = 0..TAPS.
  - upd_x_n = x[c] for c<TAPS; 0 at c=TAPS.
  - upd_weight = weight[c-1] for c>=1; 0 at c=0. The weight is skewed one cycle behind x_n to match the term's product delay.
  - For c>=1: weight[c-1] <= upd_new_weight at the end of the cycle.
  - At c=TAPS, go to DONE.
- DONE: done=1 for one cycle, then IDLE. A start arriving in DONE is ignored.
- busy=1 in UPDATE and DONE.
- start while busy is ignored. No queuing; the sample is lost. The upstream stage must wait for done.
- upd_mu_error is driven from the hold register and stays stable for the whole pass, including DONE.
- Pass latency: start edge to done pulse = TAPS+2 cycles. Next start is accepted in the cycle after done.
- rd_data is combinational from the weight registers. It shows the old value until the write edge of that tap; no bypass.
- The bank performs no arithmetic. Width and rounding rules are owned by the update term.
- Asynchronous reset mid-pass aborts immediately to the reset state. A partially updated weight vector is discarded (everything cleared).

Optional Feature:
- Macro W_BANK_CENTER_INIT_EN.
- Defined: reset loads weight[TAPS/2] = 1<<QP (1.0) and all other weights 0, giving an identity-like starting filter.
- Undefined: all weights reset to 0.
- Delay-line and control behaviour are identical in both builds.

Decomposition:
- Shared package: state encoding (IDLE/UPDATE/DONE), the ONE_Q constant (1<<QP), and the tap-index width function.
- Natural sub-module: w_tap_delay_line, a TAPS-deep WIDTH-wide shift register with load enable and parallel outputs.
- The FSM, counter and weight registers stay in w_tap_bank.

Test Plan:
- Reset, then read all taps via rd_addr -> rd_data=0 for all taps; with W_BANK_CENTER_INIT_EN, tap 4 = 0x1000 (TAPS=8, QP=12).
- Bench models the term (new_weight = weight + registered x_n*mu_error>>QP). Drive start, x_in=0x1000, mu_error=0x0800 -> done exactly 10 cycles after start; weight[0]=0x0800, others unchanged.
- Second pass, x_in=0x2000, mu_error=0x0400 -> x[0]=0x2000, x[1]=0x1000; weight[0]=0x0800+0x0800=0x1000, weight[1]=0x0400.
- Pulse start at c=3 of a pass and again in DONE -> both ignored; delay line not shifted; hold register unchanged.
- Drop reset low at c=5 -> outputs go to 0 immediately; after release, all weights are 0 and state is IDLE.
- Read rd_addr=2 during a pass -> old value until the edge ending c=3, new value from then on.
